// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg: shared default sizes and select-width helper for the stream mux family
package rr_stream_mux_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH = 4;
  function automatic int sel_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

`define RR_SELW(n) ((n) < 2 ? 1 : $clog2(n))

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter: combinational round-robin / forced-select grant logic
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
  output logic            grant_valid,
  output logic [SELW-1:0] g
);
  always_comb begin
    grant_valid = 1'b0;
    g = '0;
    if (force_en) begin
      if (int'(force_sel) < NCH && req[force_sel]) begin
        grant_valid = 1'b1;
        g = force_sel;
      end
    end else begin
      // scan downward so the last hit written is the first valid at or after ptr
      for (int k = NCH - 1; k >= 0; k--)
        if (req[(int'(ptr) + k) % NCH]) begin
          grant_valid = 1'b1;
          g = SELW'((int'(ptr) + k) % NCH);
        end
    end
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N-to-1 valid/ready mux with round-robin or forced channel select
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]     in_ready,
  input  logic               force_en,
  input  logic [SELW-1:0]    force_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);
  logic [SELW-1:0] ptr, g;
  logic grant_valid, load, xfer;
  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req(in_valid), .ptr(ptr), .force_en(force_en), .force_sel(force_sel),
    .grant_valid(grant_valid), .g(g)
  );
  always_comb begin
    load = !out_valid || out_ready;
    xfer = !rst && load && grant_valid;
    in_ready = xfer ? NCH'(1) << g : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= in_data[g*WIDTH +: WIDTH];
        out_sel <= g;
        ptr <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
      end
    end
  end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Registered N-to-1 stream multiplexer: selects one of `NCH` valid/ready input channels of `WIDTH` bits per beat. Channels are chosen by fair round-robin arbitration, or by a static select when forced. It is the parametrised, flow-controlled successor to the 2:1 combinational mux. It sits between multiple producers and a single downstream consumer, with one cycle of registered latency.

## Interface
Parameters:
- `WIDTH`, 8: data bits per channel
- `NCH`, 4: number of input channels, ≥2
- `SELW`, `$clog2(NCH)`: derived; width of select/index fields; not overridden

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  NCH  per-channel valid, bit i = channel i
- `in_data`  in  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- `in_ready`  out  NCH  per-channel ready; combinational
- `force_en`  in  1  1 = static select mode
- `force_sel`  in  SELW  channel used when `force_en`=1
- `out_valid`  out  1  output register holds a beat
- `out_data`  out  WIDTH  registered data
- `out_sel`  out  SELW  index of the channel that produced `out_data`
- `out_ready`  in  1  downstream accepts beat

## Operation
- Output stage: one register holding `out_valid`, `out_data` and `out_sel`.
- `load = !out_valid || out_ready`. This allows a full-throughput refill in the same cycle a beat drains.
- Arbitration mode (`force_en`=0):
  - Search the valid channels starting at pointer `ptr`, upward with wrap-around.
  - The first valid channel found is the grant `g`.
- Forced mode (`force_en`=1):
  - `g = force_sel`, only if `in_valid[force_sel]`; otherwise there is no grant.
  - `force_sel` ≥ `NCH` means no grant.
- `in_ready[i] = load && grant_valid && (g == i)`. At most one bit of `in_ready` is set. `in_ready` never depends on `in_valid[i]` of other channels in forced mode.
- On a transfer (`in_valid[g] && in_ready[g]`), at the next edge:
  - `out_data` ← channel g data, `out_sel` ← g, `out_valid` ← 1.
  - `ptr` ← (g+1) mod NCH. The wrap from NCH-1 goes to 0; a non-power-of-2 `NCH` must wrap correctly.
- `load` with no grant: `out_valid` ← 0, and `out_data`/`out_sel` hold their values.
- `ptr` advances only on transfers, including transfers made in forced mode. This keeps fairness on the return to arbitration.
- Held output (`out_valid`=1 and `out_ready`=0):
  - `out_data` and `out_sel` stay stable.
  - All `in_ready` bits are 0.
- Switching `force_en` mid-stream takes effect on the grant in the same cycle. A beat already registered is unaffected.

## Timing
- Reset (`rst`=1 at an edge) sets `out_valid`=0, `out_data`=0, `out_sel`=0 and `ptr`=0.
- While `rst`=1, `in_ready`=0 irrespective of other inputs.
- Reset mid-stream discards the registered beat. No partial state survives.
- Latency: an input beat accepted at edge k appears on `out_*` after edge k.
- Throughput: 1 beat/cycle sustained when `out_ready`=1.
- Fairness: with all channels continuously valid, grants rotate 0,1,…,NCH-1,0.
- Input handshake: a producer must hold data and valid until it sees `in_ready`. The block does not assume this; it samples only on the transfer cycle.
- No combinational path from `out_ready` to `out_data`. A path from `out_ready` to `in_ready` is permitted and expected.

## Structure
- A shared package/include holds the default `WIDTH`/`NCH` constants and a `clog2`-safe `SELW` macro for benches.
- One sub-module, `rr_arbiter`: inputs are the request vector, `ptr`, `force_en` and `force_sel`; outputs are `grant_valid` and `g`. It is purely combinational and reusable by other stream blocks.
- The top level holds `ptr`, the output register and the `in_ready` decode.

## Test plan
- All channels valid, `out_ready`=1, data = 0x10+i → `out_sel` sequence 0,1,2,3,0; `out_data` 0x10,0x11,0x12,0x13,0x10; one beat per cycle.
- Only channel 2 valid, `ptr`=0 → grant 2; then channels 0 and 3 valid → grant 3, then 0.
- `out_ready`=0 for 3 cycles with a beat held → `out_data`/`out_sel` stable and `in_ready`=0000. Release → next beat follows the next cycle with no loss or duplication.
- `force_en`=1, `force_sel`=1, all channels valid → only channel 1 transfers. `force_sel`=1 with `in_valid[1]`=0 → `out_valid` drops after draining. Return to `force_en`=0 → next grant is channel 2.
- `NCH`=3 build, all valid → wrap 0,1,2,0. `force_sel`=3 → no grant.
- Assert `rst` while `out_valid`=1 → after the edge, `out_valid`=0, `out_data`=0 and `out_sel`=0, and the next grant is channel 0.
